// File: rtl/i2c_pkg.sv
// Shared types for the I2C command scheduler: bus widths, FSM encoding and the
// command record carried through the FIFO.
package i2c_pkg;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CMD_W  = 1 + ADDR_W + DATA_W;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_RESP      = 2'd3
  } state_e;

  typedef struct packed {
    logic              rw_bar;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/i2c_cmd_fifo.sv
// Small synchronous FIFO; the head entry is presented straight from the storage
// registers so a pop can load it in the same cycle.
module i2c_cmd_fifo #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  do_push_c;
  logic                  do_pop_c;

  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign do_pop_c  = pop && !empty;
  // A full FIFO may still accept a write when the head leaves in the same cycle.
  assign do_push_c = push && (!full || do_pop_c);
  assign dout      = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push_c) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push_c) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (do_pop_c)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      case ({do_push_c, do_pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/i2c_cmd_scheduler.sv
// Queues host I2C commands and issues them one at a time to the master
// controller, returning one response (read data / timeout flag) per command.
module i2c_cmd_scheduler
  import i2c_pkg::*;
#(
  parameter int unsigned CMD_DEPTH_LOG2 = 2,
  parameter int unsigned HOLD_CYC       = 24,
  parameter int unsigned TIMEOUT_CYC    = 4096
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw_bar,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_rw_bar,
  output logic              m_new_data,
  output logic              m_rw_bar,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_done,
  output logic              busy
);

  localparam int unsigned HOLD_W = $clog2(HOLD_CYC);
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYC);

  state_e            state;
  cmd_t              cmd_in;
  cmd_t              head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push_c;
  logic              pop_c;
  logic [HOLD_W-1:0] hold_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic              done_s;
  logic              done_p;
  logic              done_rise_c;
  logic              to_hit_c;

  assign cmd_in      = '{rw_bar: cmd_rw_bar, addr: cmd_addr, wdata: cmd_wdata};
  assign cmd_ready   = !fifo_full;
  assign push_c      = cmd_valid && !fifo_full;
  assign pop_c       = (state == ST_IDLE) && !fifo_empty && !rsp_valid;
  assign busy        = (state != ST_IDLE) || !fifo_empty;
  assign done_rise_c = done_s && !done_p;
  assign to_hit_c    = (to_cnt == TO_W'(TIMEOUT_CYC - 1));

  i2c_cmd_fifo #(
    .WIDTH     (CMD_W),
    .DEPTH_LOG2(CMD_DEPTH_LOG2)
  ) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (push_c),
    .pop    (pop_c),
    .din    (cmd_in),
    .dout   (head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Sequencer: issue pulse, completion/timeout race, response hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      hold_cnt   <= '0;
      to_cnt     <= '0;
      done_s     <= 1'b0;
      done_p     <= 1'b0;
      m_new_data <= 1'b0;
      m_rw_bar   <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      rsp_rw_bar <= 1'b0;
    end else begin
      done_s <= m_done;
      done_p <= done_s;
      case (state)
        ST_IDLE: begin
          hold_cnt <= '0;
          to_cnt   <= '0;
          if (pop_c) begin
            m_rw_bar   <= head.rw_bar;
            m_addr     <= head.addr;
            m_wdata    <= head.wdata;
            m_new_data <= 1'b1;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (to_hit_c) begin
            m_new_data <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_err    <= 1'b1;
            rsp_rdata  <= '0;
            rsp_rw_bar <= m_rw_bar;
            state      <= ST_RESP;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
            if (hold_cnt == HOLD_W'(HOLD_CYC - 1)) begin
              m_new_data <= 1'b0;
              state      <= ST_WAIT_DONE;
            end else begin
              hold_cnt <= hold_cnt + HOLD_W'(1);
            end
          end
        end
        ST_WAIT_DONE: begin
          // A fresh edge beats a timeout landing in the same cycle.
          if (done_rise_c) begin
            rsp_valid  <= 1'b1;
            rsp_err    <= 1'b0;
            rsp_rdata  <= m_rw_bar ? m_rdata : '0;
            rsp_rw_bar <= m_rw_bar;
            state      <= ST_RESP;
          end else if (to_hit_c) begin
            rsp_valid  <= 1'b1;
            rsp_err    <= 1'b1;
            rsp_rdata  <= '0;
            rsp_rw_bar <= m_rw_bar;
            state      <= ST_RESP;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
